// File: rtl/tlc_pkg.sv
// Shared lamp codes, state encoding and helpers for traffic_light_ctrl_n.
// S_WALK exists only when TLC_PED_EN is defined.
package tlc_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

`ifdef TLC_PED_EN
  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_WALK   = 2'd3
  } tlc_state_e;
`else
  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2
  } tlc_state_e;
`endif

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts up from 0 after clr, saturates at limit, done while count==limit.
module phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic [TW-1:0] limit,
  output logic          done
);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (r_count != limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done = (r_count == limit);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// Round-robin Moore traffic-light sequencer for N_STREETS approaches.
// Define TLC_PED_EN to add the pedestrian request latch, walk lamp and S_WALK phase.
module traffic_light_ctrl_n
  import tlc_pkg::*;
#(
  parameter int N_STREETS        = 2,
  parameter int MIN_GREEN_CYCLES = 3,
  parameter int YELLOW_CYCLES    = 5,
  parameter int ALL_RED_CYCLES   = 1,
  parameter int WALK_CYCLES      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_STREETS-1:0]         T,
  output logic [2*N_STREETS-1:0]       L,
  output logic [$clog2(N_STREETS)-1:0] cur
`ifdef TLC_PED_EN
  ,
  input  logic                         ped_req,
  output logic                         walk
`endif
);

  localparam int CW   = $clog2(N_STREETS);
  localparam int MAXD = f_max(f_max(MIN_GREEN_CYCLES, YELLOW_CYCLES),
                              f_max(ALL_RED_CYCLES, WALK_CYCLES));
  localparam int TW   = $clog2(MAXD) + 1;

  // Green saturates at MIN_GREEN; timed phases end on their last cycle (count N-1).
  localparam logic [TW-1:0] LIM_GREEN  = TW'(MIN_GREEN_CYCLES);
  localparam logic [TW-1:0] LIM_YELLOW = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] LIM_ALLRED = TW'((ALL_RED_CYCLES > 0) ? ALL_RED_CYCLES - 1 : 0);
`ifdef TLC_PED_EN
  localparam logic [TW-1:0] LIM_WALK   = TW'((WALK_CYCLES > 0) ? WALK_CYCLES - 1 : 0);
`endif

  tlc_state_e    r_state;
  tlc_state_e    w_state_nxt;
  logic [CW-1:0] r_cur;
  logic [CW-1:0] w_cur_nxt;
  logic [TW-1:0] w_limit;
  logic          w_clr;
  logic          w_done;
`ifdef TLC_PED_EN
  logic          r_ped;
`endif

  function automatic logic [CW-1:0] f_next(input logic [CW-1:0] c,
                                           input logic [N_STREETS-1:0] t);
    int   idx;
    logic found;
    f_next = CW'((int'(c) + 1) % N_STREETS);
    found  = 1'b0;
    for (int k = 1; k < N_STREETS; k++) begin
      idx = (int'(c) + k) % N_STREETS;
      if (!found && t[CW'(idx)]) begin
        f_next = CW'(idx);
        found  = 1'b1;
      end
    end
  endfunction

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .limit (w_limit),
    .done  (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_GREEN;
      r_cur   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_limit     = LIM_GREEN;
    case (r_state)
      S_GREEN: begin
        w_limit = LIM_GREEN;
        if (w_done && !T[r_cur]) w_state_nxt = S_YELLOW;
      end
      S_YELLOW: begin
        w_limit = LIM_YELLOW;
        if (w_done) begin
`ifdef TLC_PED_EN
          if (r_ped) begin
            w_state_nxt = S_WALK;
          end else
`endif
          if (ALL_RED_CYCLES > 0) begin
            w_state_nxt = S_ALLRED;
          end else begin
            w_state_nxt = S_GREEN;
            w_cur_nxt   = f_next(r_cur, T);
          end
        end
      end
      S_ALLRED: begin
        w_limit = LIM_ALLRED;
        if (w_done) begin
          w_state_nxt = S_GREEN;
          w_cur_nxt   = f_next(r_cur, T);
        end
      end
`ifdef TLC_PED_EN
      S_WALK: begin
        w_limit = LIM_WALK;
        if (w_done) begin
          if (ALL_RED_CYCLES > 0) begin
            w_state_nxt = S_ALLRED;
          end else begin
            w_state_nxt = S_GREEN;
            w_cur_nxt   = f_next(r_cur, T);
          end
        end
      end
`endif
      default: begin
        w_state_nxt = S_GREEN;
        w_cur_nxt   = '0;
      end
    endcase
  end

  assign w_clr = (w_state_nxt != r_state);

`ifdef TLC_PED_EN
  // A request in the cycle that enters S_WALK is kept for the following exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ped <= 1'b0;
    end else if (r_state != S_WALK) begin
      if (w_state_nxt == S_WALK) r_ped <= ped_req;
      else if (ped_req)          r_ped <= 1'b1;
    end
  end

  assign walk = (r_state == S_WALK);
`endif

  always_comb begin
    L = {N_STREETS{LIGHT_RED}};
    for (int i = 0; i < N_STREETS; i++) begin
      if (i == int'(r_cur)) begin
        if (r_state == S_GREEN)       L[2*i +: 2] = LIGHT_GREEN;
        else if (r_state == S_YELLOW) L[2*i +: 2] = LIGHT_YELLOW;
      end
    end
  end

  assign cur = r_cur;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n (2-street and 4-street instances).
// Pedestrian scenario compiles in only when TLC_PED_EN is defined.
module tb_traffic_light_ctrl_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] T2;
  logic [3:0] T4;
  logic [3:0] L2;
  logic [7:0] L4;
  logic       cur2;
  logic [1:0] cur4;
`ifdef TLC_PED_EN
  logic       ped2, walk2, ped4, walk4;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_n #(.N_STREETS(2)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .T       (T2),
    .L       (L2),
    .cur     (cur2)
`ifdef TLC_PED_EN
    ,
    .ped_req (ped2),
    .walk    (walk2)
`endif
  );

  traffic_light_ctrl_n #(.N_STREETS(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .T       (T4),
    .L       (L4),
    .cur     (cur4)
`ifdef TLC_PED_EN
    ,
    .ped_req (ped4),
    .walk    (walk4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    T2    = 2'b00;
    T4    = 4'b0000;
`ifdef TLC_PED_EN
    ped2  = 1'b0;
    ped4  = 1'b0;
`endif

    // Reset state, then full cycle street 0 -> street 1; N=4 skips to street 3.
    @(negedge clk);
    chk("rst_L2", 32'(L2), 'b1000);
    chk("rst_cur2", 32'(cur2), 0);
    chk("rst_L4", 32'(L4), 'b10101000);
`ifdef TLC_PED_EN
    chk("rst_walk", 32'(walk2), 0);
`endif
    #3;
    reset = 1'b1;
    T4    = 4'b1000;
    repeat (3) begin
      @(negedge clk);
      chk("s1_green", 32'(L2), 'b1000);
    end
    repeat (5) begin
      @(negedge clk);
      chk("s1_yellow", 32'(L2), 'b1001);
    end
    chk("s3_yellow4", 32'(L4), 'b10101001);
    @(negedge clk);
    chk("s1_allred", 32'(L2), 'b1010);
    chk("s3_allred4", 32'(L4), 'b10101010);
    chk("s3_cur_hold", 32'(cur4), 0);
    @(negedge clk);
    chk("s1_green1", 32'(L2), 'b0010);
    chk("s1_cur1", 32'(cur2), 1);
    chk("s3_cur_skip", 32'(cur4), 3);
    chk("s3_green3", 32'(L4), 'b00101010);

    // Async reset while street 1 is yellow.
    repeat (3) begin
      @(negedge clk);
      chk("s6_green1", 32'(L2), 'b0010);
    end
    @(negedge clk);
    chk("s6_yellow1", 32'(L2), 'b0110);
    #2;
    reset = 1'b0;
    #1;
    chk("s6_async_L", 32'(L2), 'b1000);
    chk("s6_async_cur", 32'(cur2), 0);
`ifdef TLC_PED_EN
    chk("s6_async_walk", 32'(walk2), 0);
`endif

    // Sensor holds green; yellow one cycle after it drops.
    T2 = 2'b01;
    pulse_reset();
    repeat (20) begin
      @(negedge clk);
      chk("s2_hold", 32'(L2[1:0]), 'b00);
    end
    T2 = 2'b00;
    @(negedge clk);
    chk("s2_yellow", 32'(L2[1:0]), 'b01);

    // Early sensor drop cannot cut the minimum green short.
    T2 = 2'b01;
    pulse_reset();
    @(negedge clk);
    chk("s4_g1", 32'(L2), 'b1000);
    T2 = 2'b00;
    @(negedge clk);
    chk("s4_g2", 32'(L2), 'b1000);
    @(negedge clk);
    chk("s4_g3", 32'(L2), 'b1000);
    @(negedge clk);
    chk("s4_yellow", 32'(L2), 'b1001);

`ifdef TLC_PED_EN
    // Pedestrian walk after yellow; a request during walk is ignored.
    T2 = 2'b00;
    pulse_reset();
    @(negedge clk);
    ped2 = 1'b1;
    @(negedge clk);
    ped2 = 1'b0;
    chk("s5_green", 32'(L2), 'b1000);
    @(negedge clk);
    @(negedge clk);
    chk("s5_yellow", 32'(L2), 'b1001);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s5_walk", 32'(walk2), 1);
      chk("s5_walk_L", 32'(L2), 'b1010);
      ped2 = (k == 0);
    end
    ped2 = 1'b0;
    @(negedge clk);
    chk("s5_walk_end", 32'(walk2), 0);
    chk("s5_allred", 32'(L2), 'b1010);
    @(negedge clk);
    chk("s5_green1", 32'(L2), 'b0010);
    chk("s5_cur1", 32'(cur2), 1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("s5_yellow1", 32'(L2), 'b0110);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("s5_no_walk", 32'(walk2), 0);
    chk("s5_allred2", 32'(L2), 'b1010);
    @(negedge clk);
    chk("s5_green0", 32'(L2), 'b1000);
    chk("s5_cur0", 32'(cur2), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
